// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control path: opcodes, FSM states,
// and the ALUOp / ALUSrcB codes also used by the ALU control decoder.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        EXEC_R,
        EXEC_I,
        WB_ALU,
        BRANCH
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_FOUR = 2'b01,
        SRCB_IMM  = 2'b10
    } srcb_t;

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V sequencer: steps FETCH/DECODE/EXEC/MEM/WB one instruction at a
// time, holds memory requests until mem_ready, and counts retired instructions.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             PCSource,
    output logic [1:0]       ALUOp,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic             pc_write;
    logic             pc_write_cond;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            FETCH:     if (mem_ready) state_d = DECODE;
            DECODE: begin
                unique case (opcode)
                    OP_LD, OP_SD: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = EXEC_R;
                    OP_ADDI:      state_d = EXEC_I;
                    OP_BEQ:       state_d = BRANCH;
                    default:      state_d = FETCH;
                endcase
            end
            MEM_ADDR:  state_d = (opcode == OP_SD) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (mem_ready) state_d = MEM_WB;
            MEM_WB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXEC_R:    state_d = WB_ALU;
            EXEC_I:    state_d = WB_ALU;
            WB_ALU, BRANCH: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default:   state_d = FETCH;
        endcase
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    // Everything except pc_en, IRWrite and illegal is a pure function of the state.
    always_comb begin
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        PCSource      = 1'b0;
        ALUOp         = ALUOP_ADD;
        illegal       = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        unique case (state_q)
            FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                IRWrite  = mem_ready;
                pc_write = mem_ready;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMM;
                unique case (opcode)
                    OP_LD, OP_SD, OP_RTYPE, OP_ADDI, OP_BEQ: illegal = 1'b0;
                    default:                                 illegal = 1'b1;
                endcase
            end
            MEM_ADDR, EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            WB_ALU:    RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALUOP_SUB;
                pc_write_cond = 1'b1;
                PCSource      = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_en   = pc_write | (pc_write_cond & zero);
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle
// and compares the full control word and instret against hand-derived values.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite;
    logic        ALUSrcA, PCSource, illegal;
    logic [1:0]  ALUSrcB, ALUOp;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .illegal(illegal),
        .instret(instret)
    );

    always #5 clk = ~clk;

    // Control word: pc_en IorD MemRead MemWrite IRWrite MemtoReg RegWrite ALUSrcA ALUSrcB[1:0] PCSource ALUOp[1:0] illegal
    localparam logic [13:0] W_FETCH_RDY  = 14'b1_0_1_0_1_0_0_0_01_0_00_0;
    localparam logic [13:0] W_FETCH_WAIT = 14'b0_0_1_0_0_0_0_0_01_0_00_0;
    localparam logic [13:0] W_DECODE     = 14'b0_0_0_0_0_0_0_0_10_0_00_0;
    localparam logic [13:0] W_DECODE_ILL = 14'b0_0_0_0_0_0_0_0_10_0_00_1;
    localparam logic [13:0] W_ADDR_IMM   = 14'b0_0_0_0_0_0_0_1_10_0_00_0;
    localparam logic [13:0] W_MEM_READ   = 14'b0_1_1_0_0_0_0_0_00_0_00_0;
    localparam logic [13:0] W_MEM_WB     = 14'b0_0_0_0_0_1_1_0_00_0_00_0;
    localparam logic [13:0] W_MEM_WRITE  = 14'b0_1_0_1_0_0_0_0_00_0_00_0;
    localparam logic [13:0] W_EXEC_R     = 14'b0_0_0_0_0_0_0_1_00_0_10_0;
    localparam logic [13:0] W_WB_ALU     = 14'b0_0_0_0_0_0_1_0_00_0_00_0;
    localparam logic [13:0] W_BRANCH_T   = 14'b1_0_0_0_0_0_0_1_00_1_01_0;
    localparam logic [13:0] W_BRANCH_N   = 14'b0_0_0_0_0_0_0_1_00_1_01_0;

    function automatic logic [13:0] ctrl_word();
        return {pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal};
    endfunction

    // Drive mem_ready for this cycle, check outputs once settled, then advance one edge.
    task automatic cyc(input string tag, input logic mr, input logic [13:0] exp_w,
                       input logic [31:0] exp_cnt);
        logic [13:0] obs_w;
        mem_ready = mr;
        #1;
        obs_w = ctrl_word();
        checks++;
        assert (obs_w === exp_w) else begin
            errors++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs_w, exp_w);
        end
        checks++;
        assert (instret === exp_cnt) else begin
            errors++;
            $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, exp_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 7'b0110011;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc("reset_hold", 1'b1, W_FETCH_RDY, 32'd0);
        reset = 1'b0;

        // R-type, plus one FETCH stall
        cyc("r_fetch_wait", 1'b0, W_FETCH_WAIT, 32'd0);
        cyc("r_fetch",      1'b1, W_FETCH_RDY,  32'd0);
        cyc("r_decode",     1'b0, W_DECODE,     32'd0);
        cyc("r_exec",       1'b0, W_EXEC_R,     32'd0);
        cyc("r_wb",         1'b1, W_WB_ALU,     32'd0);

        // LD with three wait cycles in MEM_READ
        opcode = 7'b0000011;
        cyc("ld_fetch",  1'b1, W_FETCH_RDY, 32'd1);
        cyc("ld_decode", 1'b1, W_DECODE,    32'd1);
        cyc("ld_addr",   1'b1, W_ADDR_IMM,  32'd1);
        cyc("ld_rd_w0",  1'b0, W_MEM_READ,  32'd1);
        cyc("ld_rd_w1",  1'b0, W_MEM_READ,  32'd1);
        cyc("ld_rd_w2",  1'b0, W_MEM_READ,  32'd1);
        cyc("ld_rd",     1'b1, W_MEM_READ,  32'd1);
        cyc("ld_wb",     1'b0, W_MEM_WB,    32'd1);

        // BEQ taken
        opcode = 7'b1100011;
        zero   = 1'b1;
        cyc("beq_t_fetch",  1'b1, W_FETCH_RDY, 32'd2);
        cyc("beq_t_decode", 1'b1, W_DECODE,    32'd2);
        cyc("beq_t_branch", 1'b1, W_BRANCH_T,  32'd2);

        // BEQ not taken
        zero = 1'b0;
        cyc("beq_n_fetch",  1'b1, W_FETCH_RDY, 32'd3);
        cyc("beq_n_decode", 1'b1, W_DECODE,    32'd3);
        cyc("beq_n_branch", 1'b1, W_BRANCH_N,  32'd3);

        // ADDI
        opcode = 7'b0010011;
        cyc("addi_fetch",  1'b1, W_FETCH_RDY, 32'd4);
        cyc("addi_decode", 1'b1, W_DECODE,    32'd4);
        cyc("addi_exec",   1'b1, W_ADDR_IMM,  32'd4);
        cyc("addi_wb",     1'b1, W_WB_ALU,    32'd4);

        // SD with one write wait
        opcode = 7'b0100011;
        cyc("sd_fetch",   1'b1, W_FETCH_RDY, 32'd5);
        cyc("sd_decode",  1'b1, W_DECODE,    32'd5);
        cyc("sd_addr",    1'b1, W_ADDR_IMM,  32'd5);
        cyc("sd_wr_wait", 1'b0, W_MEM_WRITE, 32'd5);
        cyc("sd_wr",      1'b1, W_MEM_WRITE, 32'd5);

        // Illegal opcode
        opcode = 7'b1111111;
        cyc("ill_fetch",  1'b1, W_FETCH_RDY,  32'd6);
        cyc("ill_decode", 1'b1, W_DECODE_ILL, 32'd6);
        cyc("ill_return", 1'b0, W_FETCH_WAIT, 32'd6);

        // Reset while a store is waiting on memory
        opcode = 7'b0100011;
        cyc("rst_fetch",  1'b1, W_FETCH_RDY, 32'd6);
        cyc("rst_decode", 1'b1, W_DECODE,    32'd6);
        cyc("rst_addr",   1'b0, W_ADDR_IMM,  32'd6);
        reset = 1'b1;
        cyc("rst_in_wr",  1'b0, W_MEM_WRITE, 32'd6);
        reset = 1'b0;
        cyc("rst_after",  1'b0, W_FETCH_WAIT, 32'd0);
        cyc("rst_resume", 1'b1, W_FETCH_RDY,  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
